// File: rtl/button_pkg.sv
// Shared constants for the push-button controller: register addresses and
// the default debounce interval.
package button_pkg;

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;

    // 1 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_TICKS = 50000;

endpackage : button_pkg

// File: rtl/button_debounce_cell.sv
// One key: 2-flop synchronizer, hold-time counter, debounced level and a
// single-cycle press pulse coincident with the level update.
module button_debounce_cell
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic fall
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             terminal;

    assign mismatch = (sync_2 != stable_q);
    assign terminal = mismatch && (cnt == TERM);

    // Sync flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Any return to the old level clears the count, rejecting short glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b1;
            cnt      <= '0;
        end else if (!mismatch) begin
            cnt <= '0;
        end else if (terminal) begin
            stable_q <= sync_2;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Combinational so the edge register sets on the same edge as the level.
    assign fall   = terminal && !sync_2;
    assign stable = stable_q;

endmodule : button_debounce_cell

// File: rtl/button_debounce_ctrl.sv
// Avalon-MM push-button controller: debounced key state, per-bit irq mask and
// a write-one-to-clear press-event register driving a level interrupt.
module button_debounce_ctrl
    import button_pkg::*;
#(
    parameter int WIDTH          = 5,
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    // Bus protocol: no wait states. A write takes effect on the edge where
    // chipselect && !write_n; readdata is registered from address on every
    // edge regardless of chipselect, so it is valid one cycle after address.

    logic [WIDTH-1:0] key_state;
    logic [WIDTH-1:0] key_fall;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rd_mux;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        button_debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .CNT_W         (CNT_W)
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (in_port[i]),
            .stable (key_state[i]),
            .fall   (key_fall[i])
        );
    end

    assign wr_en    = chipselect && !write_n;
    assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (wr_en && address == ADDR_MASK) begin
            mask_q <= writedata;
        end
    end

    // A new event wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | key_fall;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATE: rd_mux = key_state;
            ADDR_MASK:  rd_mux = mask_q;
            ADDR_EDGE:  rd_mux = edge_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_q & mask_q);

endmodule : button_debounce_ctrl

// File: tb/tb_button_debounce_ctrl.sv
// Directed bench for button_debounce_ctrl with DEBOUNCE_TICKS = 4: reset,
// press timing, glitch rejection, irq/W1C, set/clear collision, mid-count reset.
module tb_button_debounce_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [W-1:0] writedata = '0;
    logic [W-1:0] in_port = '1;
    logic [W-1:0] readdata;
    logic         irq;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_compared = 0;
    int           n_mismatched = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    button_debounce_ctrl #(
        .WIDTH         (W),
        .DEBOUNCE_TICKS(4),
        .CNT_W         (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_read(input logic [1:0] a, input logic [W-1:0] e, input string tag);
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_read();
        logic [W-1:0] e;
        string        t;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_compared++;
            assert (readdata === e) else begin
                n_mismatched++;
                $error("FAIL %s observed=%b expected=%b", t, readdata, e);
            end
        end
    endtask

    task automatic read(input logic [1:0] a, input logic [W-1:0] e, input string tag);
        expect_read(a, e, tag);
        cycle();
        check_read();
    endtask

    task automatic check_irq(input logic e, input string tag);
        n_compared++;
        assert (irq === e) else begin
            n_mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, irq, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #2;
        cycle(2);
        check_irq(1'b0, "reset_irq_in_reset");
        n_compared++;
        assert (readdata === '0) else begin
            n_mismatched++;
            $error("FAIL reset_readdata observed=%b expected=%b", readdata, 5'b0);
        end
        reset_n = 1'b1;
        cycle();

        // 1. reset values
        read(2'd0, 5'b11111, "reset_state");
        read(2'd1, 5'b00000, "reset_mask");
        read(2'd2, 5'b00000, "reset_edge");
        check_irq(1'b0, "reset_irq");

        // 2. clean press on bit 2: STATE changes on the 6th edge, visible on the 7th
        address = 2'd0;
        in_port[2] = 1'b0;
        cycle(5);
        expect_read(2'd0, 5'b11111, "press_state_edge6");
        cycle();
        check_read();
        expect_read(2'd0, 5'b11011, "press_state_edge7");
        cycle();
        check_read();
        check_irq(1'b0, "press_irq_unmasked");
        cycle(3);
        read(2'd2, 5'b00100, "press_edge");
        in_port[2] = 1'b1;
        cycle(8);
        read(2'd0, 5'b11111, "release_state");
        read(2'd2, 5'b00100, "release_no_edge");

        // 3. glitch of 3 cycles on bit 0
        in_port[0] = 1'b0;
        cycle(3);
        in_port[0] = 1'b1;
        cycle(8);
        read(2'd0, 5'b11111, "glitch_state");
        read(2'd2, 5'b00100, "glitch_edge");

        // 4. interrupt and W1C
        bus_write(2'd2, 5'b11111);
        read(2'd2, 5'b00000, "w1c_all");
        bus_write(2'd1, 5'b00100);
        read(2'd1, 5'b00100, "mask_rb");
        check_irq(1'b0, "irq_before_press");
        in_port[2] = 1'b0;
        cycle(5);
        check_irq(1'b0, "irq_edge5");
        cycle();
        check_irq(1'b1, "irq_edge6");
        cycle(2);
        bus_write(2'd2, 5'b00100);
        check_irq(1'b0, "irq_after_clear");
        read(2'd2, 5'b00000, "edge_after_clear");
        in_port[2] = 1'b1;
        cycle(8);
        read(2'd2, 5'b00000, "release_after_clear");
        check_irq(1'b0, "irq_after_release");

        // 5. W1C of bit 1 on the same edge as its fall pulse
        in_port[1] = 1'b0;
        cycle(5);
        bus_write(2'd2, 5'b00010);
        read(2'd2, 5'b00010, "collision_set_wins");
        check_irq(1'b0, "collision_irq_masked_out");
        in_port[1] = 1'b1;
        cycle(8);

        // register-map odds: addr 3 reads 0, writes to 0 and 3 ignored
        bus_write(2'd0, 5'b00000);
        bus_write(2'd3, 5'b11111);
        read(2'd3, 5'b00000, "addr3_reads_zero");
        read(2'd0, 5'b11111, "state_write_ignored");
        read(2'd1, 5'b00100, "mask_after_addr3_write");

        // simultaneous presses on bits 0 and 4
        bus_write(2'd1, 5'b10000);
        in_port[0] = 1'b0;
        in_port[4] = 1'b0;
        cycle(8);
        read(2'd2, 5'b10011, "simultaneous_edge");
        read(2'd0, 5'b01110, "simultaneous_state");
        check_irq(1'b1, "simultaneous_irq");
        in_port[0] = 1'b1;
        in_port[4] = 1'b1;
        cycle(8);
        bus_write(2'd2, 5'b11111);
        read(2'd2, 5'b00000, "clear_before_reset_test");

        // 6. reset while bit 3 count is at 2
        in_port[3] = 1'b0;
        cycle(4);
        reset_n = 1'b0;
        in_port[3] = 1'b1;
        cycle(2);
        reset_n = 1'b1;
        cycle(10);
        read(2'd0, 5'b11111, "midreset_state");
        read(2'd2, 5'b00000, "midreset_edge");
        read(2'd1, 5'b00000, "midreset_mask");
        check_irq(1'b0, "midreset_irq");

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_button_debounce_ctrl
